// File: rtl/rram_write_verify_ctrl.sv
// rram_write_verify_ctrl: program-and-verify sequencer for one RRAM crossbar core.
// Each accepted write command runs program pulse, rest gap and ADC read-back. It
// repeats until the target code is reached or the retry budget is used up, then
// it presents {PASS, RETRIES, CODE}.
// Optional macro RRAM_PULSE_RAMP_EN: each retry lengthens the program pulse by
// PULSE_STEP cycles, saturating at 2^PULSE_W-1. Without it every attempt reuses
// the commanded length.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command, ready_i high, crossbar at rest
// PROG  | write bias on selected device for the current pulse length
// GAP   | one rest cycle between program and read
// READ  | read bias for SETTLE_CYC cycles, ADC code captured on the last
// CHECK | compare code with target, retry or finish
// DONE  | result held on DATAOUT with valid_o until the consumer takes it

module rram_write_verify_ctrl #(
  parameter int NUM_WL     = 1024,
  parameter int NUM_SL     = 512,
  parameter int NUM_ADC    = 32,
  parameter int ADC_BITS   = 4,
  parameter int PULSE_W    = 8,
  parameter int SETTLE_CYC = 4,
  parameter int MAX_RETRY  = 7,
  parameter int PULSE_STEP = 2
) (
  input  logic                                 CLK,
  input  logic                                 RSTb,
  input  logic                                 valid_i,
  output logic                                 ready_i,
  input  logic [$clog2(NUM_WL)-1:0]            CMD_WL,
  input  logic [$clog2(NUM_SL)-1:0]            CMD_COL,
  input  logic                                 CMD_POL,
  input  logic [PULSE_W-1:0]                   CMD_PULSES,
  input  logic [ADC_BITS-1:0]                  CMD_TARGET,
  output logic [NUM_WL-1:0]                    WL_SEL,
  output logic [NUM_SL-1:0]                    COL_EN,
  output logic [2:0]                           BL_SEL,
  output logic [2:0]                           SL_SEL,
  output logic                                 WL_BIAS_SEL,
  output logic [$clog2(NUM_SL/NUM_ADC)-1:0]    SL_MUX_SEL,
  input  logic [NUM_ADC*ADC_BITS-1:0]          ADCOUT,
  output logic                                 valid_o,
  input  logic                                 ready_o,
  output logic [5+ADC_BITS-1:0]                DATAOUT
);

  localparam int WL_W   = $clog2(NUM_WL);
  localparam int COL_W  = $clog2(NUM_SL);
  localparam int MUX_W  = $clog2(NUM_SL / NUM_ADC);
  localparam int AIDX_W = $clog2(NUM_ADC);
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int DOUT_W = 5 + ADC_BITS;
  localparam int PMAX   = (1 << PULSE_W) - 1;

`ifdef RRAM_PULSE_RAMP_EN
  localparam int STEP_EFF = PULSE_STEP;
`else
  // ramp disabled: retries repeat the base pulse length
  localparam int STEP_EFF = 0 * PULSE_STEP;
`endif

  localparam logic [2:0] BIAS_REF   = 3'b100;
  localparam logic [2:0] BIAS_MINUS = 3'b010;
  localparam logic [2:0] BIAS_PLUS  = 3'b001;
  localparam logic [2:0] BIAS_OFF   = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE, S_PROG, S_GAP, S_READ, S_CHECK, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WL_W-1:0]       wl_q, wl_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic                  pol_q, pol_d;
  logic [ADC_BITS-1:0]   tgt_q, tgt_d;
  logic [PULSE_W-1:0]    len_q, len_d;
  logic [PULSE_W-1:0]    cnt_q, cnt_d;
  logic [SET_W-1:0]      scnt_q, scnt_d;
  logic [ADC_BITS-1:0]   code_q, code_d;
  logic [3:0]            ret_q, ret_d;
  logic [DOUT_W-1:0]     dout_q, dout_d;

  logic [NUM_WL-1:0]     wl_sel_d;
  logic [NUM_SL-1:0]     col_en_d;
  logic [2:0]            bl_d, sl_d;
  logic                  bias_d;
  logic [MUX_W-1:0]      mux_d;

  logic [ADC_BITS-1:0]   adc_arr [NUM_ADC];
  logic [AIDX_W-1:0]     adc_idx;
  logic                  pass;
  logic [PULSE_W:0]      ramp_sum;
  logic [PULSE_W-1:0]    next_len;
  logic [PULSE_W-1:0]    cmd_len;

  // unflatten the ADC bus so the column's ADC is picked with a narrow index
  for (genvar a = 0; a < NUM_ADC; a++) begin : g_adc
    assign adc_arr[a] = ADCOUT[a*ADC_BITS +: ADC_BITS];
  end

  assign adc_idx = col_q[COL_W-1:MUX_W];
  assign pass    = pol_q ? (code_q >= tgt_q) : (code_q <= tgt_q);
  assign cmd_len = (CMD_PULSES == '0) ? PULSE_W'(1) : CMD_PULSES;

  // pulse length for the next attempt, saturating at the field maximum
  always_comb begin
    ramp_sum = {1'b0, len_q} + (PULSE_W+1)'(STEP_EFF);
    if (ramp_sum > (PULSE_W+1)'(PMAX)) next_len = PULSE_W'(PMAX);
    else                               next_len = ramp_sum[PULSE_W-1:0];
  end

  // next-state, command capture and retry bookkeeping
  always_comb begin
    state_d = state_q;
    wl_d    = wl_q;
    col_d   = col_q;
    pol_d   = pol_q;
    tgt_d   = tgt_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    code_d  = code_q;
    ret_d   = ret_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i && ready_i) begin
          wl_d    = CMD_WL;
          col_d   = CMD_COL;
          pol_d   = CMD_POL;
          tgt_d   = CMD_TARGET;
          len_d   = cmd_len;
          cnt_d   = cmd_len;
          ret_d   = '0;
          state_d = S_PROG;
        end
      end
      S_PROG: begin
        if (cnt_q <= PULSE_W'(1)) state_d = S_GAP;
        else                      cnt_d   = cnt_q - PULSE_W'(1);
      end
      S_GAP: begin
        scnt_d  = SET_W'(SETTLE_CYC);
        state_d = S_READ;
      end
      S_READ: begin
        if (scnt_q <= SET_W'(1)) begin
          code_d  = adc_arr[adc_idx];
          state_d = S_CHECK;
        end else begin
          scnt_d = scnt_q - SET_W'(1);
        end
      end
      S_CHECK: begin
        if (pass || ret_q == 4'(MAX_RETRY)) begin
          dout_d  = {pass, ret_q, code_q};
          state_d = S_DONE;
        end else begin
          ret_d   = ret_q + 4'd1;
          len_d   = next_len;
          cnt_d   = next_len;
          state_d = S_PROG;
        end
      end
      S_DONE: begin
        if (ready_o) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // crossbar drive decoded from the state being entered, so it can be registered
  always_comb begin
    wl_sel_d = '0;
    col_en_d = '0;
    bl_d     = BIAS_REF;
    sl_d     = BIAS_REF;
    bias_d   = 1'b0;
    mux_d    = '0;
    if (state_d != S_IDLE) mux_d = col_d[MUX_W-1:0];
    case (state_d)
      S_PROG: begin
        if (int'(wl_d) < NUM_WL) wl_sel_d[wl_d] = 1'b1;
        col_en_d[col_d] = 1'b1;
        bias_d          = 1'b1;
        bl_d            = pol_d ? BIAS_PLUS  : BIAS_MINUS;
        sl_d            = pol_d ? BIAS_MINUS : BIAS_PLUS;
      end
      S_READ: begin
        if (int'(wl_d) < NUM_WL) wl_sel_d[wl_d] = 1'b1;
        col_en_d[col_d] = 1'b1;
        bl_d            = BIAS_PLUS;
        sl_d            = BIAS_OFF;
      end
      default: ;
    endcase
  end

  // state, command registers and registered outputs
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q     <= S_IDLE;
      wl_q        <= '0;
      col_q       <= '0;
      pol_q       <= 1'b0;
      tgt_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      scnt_q      <= '0;
      code_q      <= '0;
      ret_q       <= '0;
      dout_q      <= '0;
      WL_SEL      <= '0;
      COL_EN      <= '0;
      BL_SEL      <= BIAS_REF;
      SL_SEL      <= BIAS_REF;
      WL_BIAS_SEL <= 1'b0;
      SL_MUX_SEL  <= '0;
      ready_i     <= 1'b1;
      valid_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wl_q        <= wl_d;
      col_q       <= col_d;
      pol_q       <= pol_d;
      tgt_q       <= tgt_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      scnt_q      <= scnt_d;
      code_q      <= code_d;
      ret_q       <= ret_d;
      dout_q      <= dout_d;
      WL_SEL      <= wl_sel_d;
      COL_EN      <= col_en_d;
      BL_SEL      <= bl_d;
      SL_SEL      <= sl_d;
      WL_BIAS_SEL <= bias_d;
      SL_MUX_SEL  <= mux_d;
      ready_i     <= (state_d == S_IDLE);
      valid_o     <= (state_d == S_DONE);
    end
  end

  assign DATAOUT = dout_q;

endmodule

// File: tb/tb_rram_write_verify_ctrl.sv
// Self-checking bench for rram_write_verify_ctrl: scoreboard of expected
// results, ADC model feeding per-read codes, and a program-pulse length monitor.

module tb_rram_write_verify_ctrl;

  localparam int S    = 4;
  localparam int MAXR = 7;
  localparam int STEP = 2;

  logic         CLK = 1'b0;
  logic         RSTb;
  logic         valid_i;
  logic         ready_i;
  logic [9:0]   CMD_WL;
  logic [8:0]   CMD_COL;
  logic         CMD_POL;
  logic [7:0]   CMD_PULSES;
  logic [3:0]   CMD_TARGET;
  logic [1023:0] WL_SEL;
  logic [511:0] COL_EN;
  logic [2:0]   BL_SEL;
  logic [2:0]   SL_SEL;
  logic         WL_BIAS_SEL;
  logic [3:0]   SL_MUX_SEL;
  logic [127:0] ADCOUT = '0;
  logic         valid_o;
  logic         ready_o;
  logic [8:0]   DATAOUT;

  int n_cmp = 0;
  int n_mis = 0;

  logic [8:0]  sb[$];
  logic [3:0]  adc_codes[$];
  int          prog_lens[$];
  logic [3:0]  cur_code = '0;
  logic [8:0]  cur_col  = '0;

  rram_write_verify_ctrl #(
    .NUM_WL(1024), .NUM_SL(512), .NUM_ADC(32), .ADC_BITS(4), .PULSE_W(8),
    .SETTLE_CYC(S), .MAX_RETRY(MAXR), .PULSE_STEP(STEP)
  ) dut (
    .CLK(CLK), .RSTb(RSTb), .valid_i(valid_i), .ready_i(ready_i),
    .CMD_WL(CMD_WL), .CMD_COL(CMD_COL), .CMD_POL(CMD_POL),
    .CMD_PULSES(CMD_PULSES), .CMD_TARGET(CMD_TARGET),
    .WL_SEL(WL_SEL), .COL_EN(COL_EN), .BL_SEL(BL_SEL), .SL_SEL(SL_SEL),
    .WL_BIAS_SEL(WL_BIAS_SEL), .SL_MUX_SEL(SL_MUX_SEL), .ADCOUT(ADCOUT),
    .valid_o(valid_o), .ready_o(ready_o), .DATAOUT(DATAOUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int plen(input int p, input int n);
`ifdef RRAM_PULSE_RAMP_EN
    int v;
    v = p + n * STEP;
    return (v > 255) ? 255 : v;
`else
    return p + 0 * n;
`endif
  endfunction

  function automatic int exp_lat(input int p, input int r);
    int l;
    l = p + S + 3;
    for (int n = 1; n <= r; n++) l += plen(p, n) + S + 2;
    return l;
  endfunction

  // ADC model: new code on the first read cycle; other ADCs carry the inverse
  logic rd_prev = 1'b0;
  always @(negedge CLK) begin
    logic rd;
    rd = (BL_SEL == 3'b001) && (SL_SEL == 3'b000) && (COL_EN != '0);
    if (rd && !rd_prev) begin
      if (adc_codes.size() > 0) cur_code = adc_codes.pop_front();
      for (int a = 0; a < 32; a++)
        ADCOUT[a*4 +: 4] = (a == int'(cur_col) / 16) ? cur_code : ~cur_code;
    end
    rd_prev = rd;
  end

  // program-pulse length monitor
  int run = 0;
  always @(negedge CLK) begin
    if (WL_BIAS_SEL) run++;
    else if (run > 0) begin
      prog_lens.push_back(run);
      run = 0;
    end
  end

  task automatic send_cmd(input logic [9:0] wl, input logic [8:0] col, input logic pol,
                          input logic [7:0] pulses, input logic [3:0] tgt);
    @(negedge CLK);
    cur_col    = col;
    valid_i    = 1'b1;
    CMD_WL     = wl;
    CMD_COL    = col;
    CMD_POL    = pol;
    CMD_PULSES = pulses;
    CMD_TARGET = tgt;
    check_val("rdy_idle", ready_i, 1'b1);
    @(posedge CLK);
    #1 valid_i = 1'b0;
  endtask

  task automatic wait_result(input int lat_exp, input bit detail, input int p,
                             input logic pol, input logic [9:0] wl, input logic [8:0] col);
    bit seen;
    int lat;
    logic [6:0] ph;
    logic [8:0] exp_d;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 400 && !seen; i++) begin
      @(negedge CLK);
      if (i == 1) check_val("rdy_busy", ready_i, 1'b0);
      if (detail && i == 1) begin
        check_val("wl_bit", WL_SEL[wl], 1'b1);
        check_val("wl_ones", $countones(WL_SEL), 1);
        check_val("col_bit", COL_EN[col], 1'b1);
        check_val("col_ones", $countones(COL_EN), 1);
        check_val("mux_sel", SL_MUX_SEL, col % 16);
      end
      if (detail && i <= p + S + 1) begin
        if (i <= p)          ph = {pol ? 3'b001 : 3'b010, pol ? 3'b010 : 3'b001, 1'b1};
        else if (i == p + 1) ph = {3'b100, 3'b100, 1'b0};
        else                 ph = {3'b001, 3'b000, 1'b0};
        check_val("phase", {BL_SEL, SL_SEL, WL_BIAS_SEL}, ph);
      end
      if (valid_o) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (!seen) begin
      check_val("result_timeout", 0, 1);
    end else begin
      check_val("latency", lat, lat_exp);
      exp_d = (sb.size() > 0) ? sb.pop_front() : 9'h1ff;
      check_val("dataout", DATAOUT, exp_d);
    end
  endtask

  task automatic ack();
    ready_o = 1'b1;
    @(posedge CLK);
    #1 ready_o = 1'b0;
    @(negedge CLK);
    check_val("valid_drop", valid_o, 1'b0);
    check_val("rdy_after_ack", ready_i, 1'b1);
  endtask

  task automatic check_prog(input int p, input int attempts);
    check_val("prog_count", prog_lens.size(), attempts);
    for (int n = 0; n < attempts && n < prog_lens.size(); n++)
      check_val("prog_len", prog_lens[n], plen(p, n));
    prog_lens.delete();
  endtask

  initial begin
    int vcount;
    logic [8:0] held;
    RSTb       = 1'b0;
    valid_i    = 1'b0;
    ready_o    = 1'b0;
    CMD_WL     = '0;
    CMD_COL    = '0;
    CMD_POL    = 1'b0;
    CMD_PULSES = '0;
    CMD_TARGET = '0;
    repeat (3) @(negedge CLK);
    RSTb = 1'b1;
    @(negedge CLK);
    check_val("rst_ready", ready_i, 1'b1);
    check_val("rst_valid", valid_o, 1'b0);
    check_val("rst_data", DATAOUT, 9'd0);
    check_val("rst_wl", $countones(WL_SEL), 0);
    check_val("rst_col", $countones(COL_EN), 0);
    check_val("rst_blsl", {BL_SEL, SL_SEL, WL_BIAS_SEL}, {3'b100, 3'b100, 1'b0});
    check_val("rst_mux", SL_MUX_SEL, 4'd0);

    // reset in the middle of a long program pulse
    send_cmd(10'd5, 9'd3, 1'b1, 8'd20, 4'd9);
    repeat (3) @(negedge CLK);
    check_val("abort_wl_on", WL_SEL[5], 1'b1);
    check_val("abort_bias_on", WL_BIAS_SEL, 1'b1);
    #2 RSTb = 1'b0;
    #1;
    check_val("abort_wl", $countones(WL_SEL), 0);
    check_val("abort_blsl", {BL_SEL, SL_SEL, WL_BIAS_SEL}, {3'b100, 3'b100, 1'b0});
    check_val("abort_ready", ready_i, 1'b1);
    check_val("abort_valid", valid_o, 1'b0);
    @(negedge CLK);
    RSTb = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(negedge CLK);
      if (valid_o) vcount++;
    end
    check_val("abort_no_result", vcount, 0);
    prog_lens.delete();
    adc_codes.delete();

    // SET, first-attempt pass, full waveform check
    adc_codes.push_back(4'd10);
    sb.push_back({1'b1, 4'd0, 4'd10});
    send_cmd(10'd3, 9'd37, 1'b1, 8'd4, 4'd9);
    wait_result(11, 1'b1, 4, 1'b1, 10'd3, 9'd37);
    ack();
    check_prog(4, 1);

    // RESET polarity, pass on the second retry
    adc_codes.push_back(4'd7);
    adc_codes.push_back(4'd5);
    adc_codes.push_back(4'd2);
    sb.push_back({1'b1, 4'd2, 4'd2});
    send_cmd(10'd100, 9'd200, 1'b0, 8'd2, 4'd3);
    wait_result(exp_lat(2, 2), 1'b1, 2, 1'b0, 10'd100, 9'd200);
    ack();
    check_prog(2, 3);

    // SET, unreachable target, retry budget exhausted
    adc_codes.push_back(4'd4);
    sb.push_back({1'b0, 4'(MAXR), 4'd4});
    send_cmd(10'd1023, 9'd511, 1'b1, 8'd4, 4'd15);
    wait_result(exp_lat(4, MAXR), 1'b0, 4, 1'b1, 10'd1023, 9'd511);
    ack();
    check_prog(4, MAXR + 1);

    // result held under back-pressure while a new command waits
    adc_codes.push_back(4'd6);
    sb.push_back({1'b1, 4'd0, 4'd6});
    send_cmd(10'd10, 9'd64, 1'b1, 8'd3, 4'd0);
    wait_result(exp_lat(3, 0), 1'b0, 3, 1'b1, 10'd10, 9'd64);
    held = {1'b1, 4'd0, 4'd6};
    for (int j = 0; j < 5; j++) begin
      valid_i    = 1'b1;
      CMD_WL     = 10'($urandom);
      CMD_COL    = 9'($urandom);
      CMD_POL    = 1'($urandom);
      CMD_PULSES = 8'($urandom);
      CMD_TARGET = 4'($urandom);
      @(negedge CLK);
      check_val("hold_data", DATAOUT, held);
      check_val("hold_ready", ready_i, 1'b0);
      check_val("hold_valid", valid_o, 1'b1);
    end
    check_prog(3, 1);

    // command waiting through the handshake; zero pulse length acts as one
    cur_col    = 9'd100;
    CMD_WL     = 10'd7;
    CMD_COL    = 9'd100;
    CMD_POL    = 1'b1;
    CMD_PULSES = 8'd0;
    CMD_TARGET = 4'd1;
    adc_codes.push_back(4'd1);
    sb.push_back({1'b1, 4'd0, 4'd1});
    ready_o = 1'b1;
    @(posedge CLK);
    #1 ready_o = 1'b0;
    @(negedge CLK);
    check_val("gap_ready", ready_i, 1'b1);
    check_val("gap_valid", valid_o, 1'b0);
    @(posedge CLK);
    #1 valid_i = 1'b0;
    wait_result(exp_lat(1, 0), 1'b1, 1, 1'b1, 10'd7, 9'd100);
    ack();
    check_prog(1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
